// File: rtl/mu0_pkg.sv
// Shared MU0 memory-side definitions: bus widths, responder state encoding,
// wait-counter width and the latched request record.
package mu0_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mu0_req_t;

endpackage

// File: rtl/mu0_mem_array.sv
// Single-port synchronous RAM for the MU0 responder; read data is registered
// and reflects the old contents when the same word is written on that edge.
module mu0_mem_array
    import mu0_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  Clk,
    input  logic                  We,
    input  logic [DEPTH_LOG2-1:0] Idx,
    input  logic [DATA_W-1:0]     Din,
    output logic [DATA_W-1:0]     Dout
);

    logic [DATA_W-1:0] mem_r [0:(1<<DEPTH_LOG2)-1];

    // Storage write and registered read port.
    always_ff @(posedge Clk) begin
        if (We) begin
            mem_r[Idx] <= Din;
        end
        Dout <= mem_r[Idx];
    end

endmodule

// File: rtl/mu0_mem_resp.sv
// MU0 memory responder: Rd/Wr request, Ack completion with WAIT_CYCLES wait
// states. Optional write protection above WPROT_BASE via MU0_MEM_WPROT_EN.
module mu0_mem_resp
    import mu0_pkg::*;
#(
    parameter int                DEPTH_LOG2  = 12,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] WPROT_BASE  = 12'hF00
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    input  logic              Rd,
    input  logic              Wr,
    output logic [DATA_W-1:0] RData,
    output logic              Ack,
    output logic              Err,
    output logic              Busy
);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    mu0_req_t          req_r;
    mu0_req_t          cur_s;
    logic              go_ack_s;
    logic              prot_s;
    logic              we_s;
    logic              err_nxt_s;
    logic              rd_ok_nxt_s;
    logic              ack_r;
    logic              err_r;
    logic              busy_r;
    logic              rd_ok_r;
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] dout_s;

    // Request in view: live ports while idle, the latched copy otherwise.
    always_comb begin
        if (state_r == IDLE) begin
            cur_s.rd   = Rd;
            cur_s.wr   = Wr;
            cur_s.addr = Addr;
            cur_s.data = WData;
        end else begin
            cur_s = req_r;
        end
    end

`ifdef MU0_MEM_WPROT_EN
    assign prot_s = (cur_s.addr >= WPROT_BASE);
`else
    logic unused_wprot_s;
    assign unused_wprot_s = ^WPROT_BASE;
    assign prot_s         = 1'b0;
`endif

    // Next-state and wait-counter logic; go_ack_s marks the ACK-entry edge.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        go_ack_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cur_s.rd | cur_s.wr) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt_s = ACK;
                        go_ack_s    = 1'b1;
                    end else begin
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ACK;
                    go_ack_s    = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            ACK: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Access outcome; Reset on the ACK-entry edge suppresses the write.
    always_comb begin
        err_nxt_s   = (cur_s.rd & cur_s.wr) | (cur_s.wr & ~cur_s.rd & prot_s);
        rd_ok_nxt_s = cur_s.rd & ~cur_s.wr;
        we_s        = go_ack_s & ~Reset & cur_s.wr & ~cur_s.rd & ~prot_s;
    end

    mu0_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .Clk  (Clk),
        .We   (we_s),
        .Idx  (cur_s.addr[DEPTH_LOG2-1:0]),
        .Din  (cur_s.data),
        .Dout (dout_s)
    );

    // Control state, request latch, flag registers and held read data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            req_r   <= '0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            rd_ok_r <= 1'b0;
            rdata_r <= 16'h0000;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ack_r   <= go_ack_s;
            busy_r  <= (state_nxt_s != IDLE);
            if (state_r == IDLE) begin
                req_r <= cur_s;
            end
            if (go_ack_s) begin
                err_r   <= err_nxt_s;
                rd_ok_r <= rd_ok_nxt_s;
            end else begin
                err_r   <= 1'b0;
                rd_ok_r <= 1'b0;
            end
            if (ack_r & rd_ok_r) begin
                rdata_r <= dout_s;
            end
        end
    end

    // RAM output is shown during a successful read's Ack, then held in rdata_r.
    assign RData = (ack_r & rd_ok_r) ? dout_s : rdata_r;
    assign Ack   = ack_r;
    assign Err   = err_r;
    assign Busy  = busy_r;

endmodule
